// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the fetch PC redirect logic and the branch ALU.
package pc_redirect_unit_pkg;

    // Branch-op encoding produced by decode and consumed by the branch ALU.
    typedef enum logic [2:0] {
        OpEq     = 3'b000,
        OpNe     = 3'b001,
        OpJump   = 3'b010,
        OpNoJump = 3'b011,
        OpLt     = 3'b100,
        OpGe     = 3'b101,
        OpLtu    = 3'b110,
        OpGeu    = 3'b111
    } branch_op_e;

    // Fetch-control FSM states.
    typedef enum logic [1:0] {
        StBoot     = 2'b00,
        StRun      = 2'b01,
        StWaitTrap = 2'b10
    } redirect_state_e;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // True for the six conditional compare ops; JUMP and NO_JUMP are not branches.
    function automatic logic is_cond_op(input logic [2:0] op);
        return !((op == OpJump) || (op == OpNoJump));
    endfunction

endpackage

// File: rtl/pc_redirect_unit_perf_counter.sv
// 32-bit wrapping event counter with synchronous clear and count enable.
module perf_counter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    // Count enabled events; reset and clear both return to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= 32'd0;
        end else if (i_en) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: selects sequential / branch target / trap vector / hold each
// cycle, flushes the two younger stages on a redirect, parks fetch after a
// misaligned control transfer until the trap arrives, and counts branches.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_ex_valid,
    input  logic [2:0]  i_ex_branch_op,
    input  logic        i_branch_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_trap_valid,
    input  logic [31:0] i_trap_vector,
    output logic [31:0] o_pc,
    output logic        o_fetch_valid,
    output logic        o_flush_if_id,
    output logic        o_flush_id_ex,
    output logic        o_misalign_exc,
    output logic [31:0] o_misalign_tval,
    output logic [31:0] o_branch_cnt,
    output logic [31:0] o_taken_cnt
);

    redirect_state_e r_state;
    logic [31:0]     r_pc;
    logic            r_fetch_valid;
    logic            r_misalign_exc;
    logic [31:0]     r_misalign_tval;

    logic w_in_run;
    logic w_in_wait;
    logic w_take;
    logic w_aligned;
    logic w_redirect;
    logic w_accept;
    logic w_branch_en;
    logic w_taken_en;

    assign w_in_run  = (r_state == StRun);
    assign w_in_wait = (r_state == StWaitTrap);
    // NO_JUMP never redirects, whatever the ALU says about branch_taken.
    assign w_take    = i_ex_valid && i_branch_taken && (i_ex_branch_op != OpNoJump);
    assign w_aligned = (i_ex_target[1:0] == 2'b00);

    // Flushes fire in the decision cycle so the killed instructions drop at this edge.
    assign w_redirect = !i_rst &&
                        ((w_in_run && (i_trap_valid || w_take)) || (w_in_wait && i_trap_valid));
    assign o_flush_if_id = w_redirect;
    assign o_flush_id_ex = w_redirect;

    // A trap in the same cycle discards the EX resolution, so it is not counted.
    assign w_accept    = w_in_run && i_ex_valid && !i_trap_valid;
    assign w_branch_en = w_accept && is_cond_op(i_ex_branch_op);
    assign w_taken_en  = w_branch_en && i_branch_taken;

    // Fetch-control FSM: next PC select, fetch_valid and misalign exception registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= StBoot;
            r_pc            <= RESET_VECTOR;
            r_fetch_valid   <= 1'b0;
            r_misalign_exc  <= 1'b0;
            r_misalign_tval <= 32'd0;
        end else begin
            r_misalign_exc <= 1'b0;
            unique case (r_state)
                StBoot: begin
                    r_state       <= StRun;
                    r_fetch_valid <= 1'b1;
                end
                StRun: begin
                    if (i_trap_valid) begin
                        r_pc <= i_trap_vector;
                    end else if (w_take && w_aligned) begin
                        r_pc <= i_ex_target;
                    end else if (w_take) begin
                        // Park fetch at the current pc until the exception trap arrives.
                        r_state         <= StWaitTrap;
                        r_fetch_valid   <= 1'b0;
                        r_misalign_exc  <= 1'b1;
                        r_misalign_tval <= i_ex_target;
                    end else if (!i_stall) begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                StWaitTrap: begin
                    if (i_trap_valid) begin
                        r_pc          <= i_trap_vector;
                        r_state       <= StRun;
                        r_fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= StBoot;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc            = r_pc;
    assign o_fetch_valid   = r_fetch_valid;
    assign o_misalign_exc  = r_misalign_exc;
    assign o_misalign_tval = r_misalign_tval;

    perf_counter u_branch_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (1'b0),
        .i_en    (w_branch_en),
        .o_count (o_branch_cnt)
    );

    perf_counter u_taken_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (1'b0),
        .i_en    (w_taken_en),
        .o_count (o_taken_cnt)
    );

endmodule
